// File: rtl/fpu_cvt_pkg.sv
// Shared types and constants for the fixed-to-float converter scheduler.
package fpu_cvt_pkg;

  localparam int FIXED_W = 32;
  localparam int EXP_W   = 8;
  localparam int FLOAT_W = 32;

  localparam logic [FLOAT_W-1:0] FLOAT_ZERO = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } cvt_state_t;

endpackage

// File: rtl/fpu_rr_pick.sv
// Combinational round-robin picker: finds the first valid requester at or
// after ptr, wrapping around past the highest index.
module fpu_rr_pick #(
  parameter int NREQ  = 2,
  parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req_valid,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] gnt_idx,
  output logic             gnt_any
);

  int               w_idx;
  logic [PTR_W-1:0] w_pos;

  // Scan from the farthest offset down so the nearest valid one after ptr wins
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    w_idx   = 0;
    w_pos   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      w_idx = (int'(ptr) + i) % NREQ;
      w_pos = PTR_W'(w_idx);
      if (req_valid[w_pos]) begin
        gnt_any = 1'b1;
        gnt_idx = w_pos;
      end
    end
  end

endmodule

// File: rtl/fpu_cvt_sched.sv
// Round-robin scheduler sharing one iterative fixed-to-float converter
// between NREQ requesters. One conversion in flight at a time.
// Optional feature: define FPU_CVT_SCHED_ZERO_BYPASS_EN to answer zero
// operands directly without running the converter.
module fpu_cvt_sched
  import fpu_cvt_pkg::*;
#(
  parameter int NREQ         = 2,
  parameter int CONV_LATENCY = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*FIXED_W-1:0] req_fixed,
  input  logic [NREQ*EXP_W-1:0]   req_exp,
  output logic [NREQ-1:0]         resp_valid,
  input  logic [NREQ-1:0]         resp_ready,
  output logic [FLOAT_W-1:0]      resp_float,
  output logic [FIXED_W-1:0]      cvt_fixed,
  output logic [EXP_W-1:0]        cvt_exp,
  output logic                    cvt_load,
  input  logic [FLOAT_W-1:0]      cvt_float,
  output logic                    busy
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = $clog2(CONV_LATENCY + 1);

  cvt_state_t         r_state;
  cvt_state_t         w_state_nxt;
  logic [PTR_W-1:0]   r_ptr;
  logic [PTR_W-1:0]   r_grant;
  logic [CNT_W-1:0]   r_cnt;
  logic [FIXED_W-1:0] r_fixed;
  logic [EXP_W-1:0]   r_exp;
  logic [FLOAT_W-1:0] r_result;

  logic [PTR_W-1:0]   w_gnt_idx;
  logic               w_gnt_any;
  logic [FIXED_W-1:0] w_win_fixed;
  logic [EXP_W-1:0]   w_win_exp;
  logic               w_req_hs;
  logic               w_resp_hs;
  logic [PTR_W-1:0]   w_ptr_nxt;

  fpu_rr_pick #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req_valid (req_valid),
    .ptr       (r_ptr),
    .gnt_idx   (w_gnt_idx),
    .gnt_any   (w_gnt_any)
  );

  assign w_win_fixed = req_fixed[int'(w_gnt_idx) * FIXED_W +: FIXED_W];
  assign w_win_exp   = req_exp[int'(w_gnt_idx) * EXP_W +: EXP_W];
  assign w_req_hs    = (r_state == IDLE) && w_gnt_any;
  assign w_resp_hs   = (r_state == RESP) && resp_ready[r_grant];
  assign w_ptr_nxt   = (r_grant == PTR_W'(NREQ - 1)) ? '0 : r_grant + 1'b1;

  // Operand regs drive the converter so its inputs hold for the whole run
  assign cvt_fixed  = r_fixed;
  assign cvt_exp    = r_exp;
  assign resp_float = r_result;

  // Next-state decode and the handshake/control outputs
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    resp_valid  = '0;
    cvt_load    = 1'b0;
    busy        = (r_state != IDLE);
    case (r_state)
      IDLE: begin
        if (w_gnt_any) begin
          req_ready = NREQ'(1) << w_gnt_idx;
`ifdef FPU_CVT_SCHED_ZERO_BYPASS_EN
          w_state_nxt = (w_win_fixed == '0) ? RESP : LOAD;
`else
          w_state_nxt = LOAD;
`endif
        end
      end
      LOAD: begin
        cvt_load    = 1'b1;
        w_state_nxt = WAIT;
      end
      WAIT: begin
        if (r_cnt == '0) w_state_nxt = RESP;
      end
      RESP: begin
        resp_valid = NREQ'(1) << r_grant;
        if (resp_ready[r_grant]) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register plus operand, counter, result and pointer bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_grant  <= '0;
      r_cnt    <= '0;
      r_fixed  <= '0;
      r_exp    <= '0;
      r_result <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (w_req_hs) begin
            r_fixed <= w_win_fixed;
            r_exp   <= w_win_exp;
            r_grant <= w_gnt_idx;
`ifdef FPU_CVT_SCHED_ZERO_BYPASS_EN
            if (w_win_fixed == '0) r_result <= FLOAT_ZERO;
`endif
          end
        end
        LOAD: r_cnt <= CNT_W'(CONV_LATENCY - 1);
        WAIT: begin
          if (r_cnt == '0) r_result <= cvt_float;
          else             r_cnt    <= r_cnt - 1'b1;
        end
        RESP: begin
          if (w_resp_hs) r_ptr <= w_ptr_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_cvt_sched.sv
// Bench for fpu_cvt_sched with a behavioural converter model in place of
// the real converter. Honors FPU_CVT_SCHED_ZERO_BYPASS_EN when defined.
module tb_fpu_cvt_sched;

  localparam int NREQ = 2;
  localparam int LAT  = 64;
`ifdef FPU_CVT_SCHED_ZERO_BYPASS_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = LAT + 2;
`endif

  logic                clk = 1'b0;
  logic                reset;
  logic [NREQ-1:0]     reqValid;
  logic [NREQ-1:0]     reqReady;
  logic [NREQ*32-1:0]  reqFixed;
  logic [NREQ*8-1:0]   reqExp;
  logic [NREQ-1:0]     respValid;
  logic [NREQ-1:0]     respReady;
  logic [31:0]         respFloat;
  logic [31:0]         cvtFixed;
  logic [7:0]          cvtExp;
  logic                cvtLoad;
  logic [31:0]         cvtFloat;
  logic                busy;

  int nChecks = 0;
  int nErrors = 0;

  typedef struct {
    int          r;
    logic [31:0] f;
    logic [7:0]  e;
    logic [31:0] expF;
    int          lat;
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  fpu_cvt_sched #(
    .NREQ         (NREQ),
    .CONV_LATENCY (LAT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (reqValid),
    .req_ready  (reqReady),
    .req_fixed  (reqFixed),
    .req_exp    (reqExp),
    .resp_valid (respValid),
    .resp_ready (respReady),
    .resp_float (respFloat),
    .cvt_fixed  (cvtFixed),
    .cvt_exp    (cvtExp),
    .cvt_load   (cvtLoad),
    .cvt_float  (cvtFloat),
    .busy       (busy)
  );

  // Reference conversion: value = fixed * 2^exp, truncating extra mantissa bits
  function automatic logic [31:0] fixToFloat(logic [31:0] f, logic [7:0] e);
    logic        sign;
    logic [31:0] mag;
    logic [31:0] norm;
    int          p;
    int          ex;
    if (f == 32'd0) return 32'h0;
    sign = f[31];
    mag  = sign ? (~f + 32'd1) : f;
    p    = 0;
    for (int i = 0; i < 32; i++) if (mag[i]) p = i;
    norm = mag << (31 - p);
    ex   = p + int'($signed(e)) + 127;
    return {sign, 8'(ex), norm[30:8]};
  endfunction

  // Converter model: result appears LAT cycles after load drops, junk before
  logic [31:0] mFixed = '0;
  logic [7:0]  mExp   = '0;
  int          mCnt   = LAT - 1;

  always @(posedge clk) begin
    if (cvtLoad) begin
      mFixed <= cvtFixed;
      mExp   <= cvtExp;
      mCnt   <= LAT - 1;
    end else if (mCnt > 0) begin
      mCnt <= mCnt - 1;
    end
  end

  assign cvtFloat = (mCnt == 0) ? fixToFloat(mFixed, mExp) : 32'hdead_beef;

  task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s: actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(int r, logic [31:0] f, logic [7:0] e);
    reqFixed[r*32 +: 32] = f;
    reqExp[r*8 +: 8]     = e;
    reqValid[r]          = 1'b1;
  endtask

  task automatic doReset();
    reset     = 1'b1;
    reqValid  = '0;
    respReady = '0;
    reqFixed  = '0;
    reqExp    = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // One isolated transaction from grant through response handshake
  task automatic runOne(int r, logic [31:0] f, logic [7:0] e, logic [31:0] expF,
                        int expLat, string tag);
    int   k;
    int   loads;
    logic loadT1;
    applyStimulus(r, f, e);
    #1;
    checkOutput({tag, " req_ready"}, 32'(reqReady), 32'(1 << r));
    @(negedge clk);
    reqValid[r] = 1'b0;
    loadT1 = cvtLoad;
    k      = 1;
    loads  = 0;
    while (respValid == '0 && k < 200) begin
      if (cvtLoad) loads++;
      @(negedge clk);
      k++;
    end
    checkOutput({tag, " load_at_T1"}, 32'(loadT1), 32'(expLat > 1));
    checkOutput({tag, " load_count"}, 32'(loads), 32'(expLat > 1));
    checkOutput({tag, " latency"}, 32'(k), 32'(expLat));
    checkOutput({tag, " resp_valid"}, 32'(respValid), 32'(1 << r));
    checkOutput({tag, " resp_float"}, respFloat, expF);
    respReady[r] = 1'b1;
    @(negedge clk);
    respReady[r] = 1'b0;
    checkOutput({tag, " idle_after"}, {30'd0, busy, |respValid}, 32'd0);
  endtask

  task automatic waitGrant(string tag);
    int k = 0;
    while (reqReady == '0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) checkOutput({tag, " grant_timeout"}, 32'(k), 32'd0);
  endtask

  task automatic waitResp(string tag);
    int k = 0;
    while (respValid == '0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) checkOutput({tag, " resp_timeout"}, 32'(k), 32'd0);
  endtask

  initial begin
    vecs[0] = '{0, 32'd1,         8'd0,   32'h3f80_0000, LAT + 2};
    vecs[1] = '{1, 32'd1,         8'd1,   32'h4000_0000, LAT + 2};
    vecs[2] = '{0, 32'd13,        8'd255, 32'h40d0_0000, LAT + 2};
    vecs[3] = '{0, 32'hffff_ffff, 8'd0,   32'hbf80_0000, LAT + 2};
    vecs[4] = '{1, 32'hffff_fffa, 8'hfe,  32'hbfc0_0000, LAT + 2};
    vecs[5] = '{0, 32'h8000_0000, 8'd0,   32'hcf00_0000, LAT + 2};
    vecs[6] = '{1, 32'd0,         8'd5,   32'h0000_0000, ZERO_LAT};

    reset     = 1'b1;
    reqValid  = '0;
    respReady = '0;
    reqFixed  = '0;
    reqExp    = '0;
    @(negedge clk);
    checkOutput("reset req_ready",  32'(reqReady),  32'd0);
    checkOutput("reset resp_valid", 32'(respValid), 32'd0);
    checkOutput("reset cvt_load",   32'(cvtLoad),   32'd0);
    checkOutput("reset busy",       32'(busy),      32'd0);
    checkOutput("reset resp_float", respFloat,      32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++)
      runOne(vecs[i].r, vecs[i].f, vecs[i].e, vecs[i].expF, vecs[i].lat,
             $sformatf("vec%0d", i));

    // Contention: both valid from reset, expect 0,1,0,1
    doReset();
    reset = 1'b1;
    applyStimulus(0, 32'd3, 8'd0);
    applyStimulus(1, 32'd5, 8'd2);
    @(negedge clk);
    reset = 1'b0;
    for (int round = 0; round < 4; round++) begin
      int          owner;
      logic [31:0] expF;
      owner = round % 2;
      expF  = (owner == 0) ? 32'h4040_0000 : 32'h41a0_0000;
      waitGrant("contend");
      checkOutput($sformatf("contend%0d grant", round), 32'(reqReady), 32'(1 << owner));
      @(negedge clk);
      waitResp("contend");
      checkOutput($sformatf("contend%0d owner", round), 32'(respValid), 32'(1 << owner));
      checkOutput($sformatf("contend%0d float", round), respFloat, expF);
      respReady[owner] = 1'b1;
      @(negedge clk);
      respReady = '0;
    end

    // Backpressure: req0 response held while req1 waits; stray resp_ready[1]
    waitGrant("bp");
    checkOutput("bp grant0", 32'(reqReady), 32'd1);
    @(negedge clk);
    waitResp("bp");
    for (int c = 0; c < 20; c++) begin
      respReady = 2'b10;
      checkOutput($sformatf("bp hold%0d valid", c), 32'(respValid), 32'd1);
      checkOutput($sformatf("bp hold%0d float", c), respFloat, 32'h4040_0000);
      checkOutput($sformatf("bp hold%0d no_grant", c), 32'(reqReady), 32'd0);
      @(negedge clk);
    end
    respReady = 2'b01;
    @(negedge clk);
    respReady = '0;
    #1;
    checkOutput("bp grant1", 32'(reqReady), 32'd2);
    @(negedge clk);
    reqValid = '0;
    waitResp("bp");
    checkOutput("bp resp1 owner", 32'(respValid), 32'd2);
    checkOutput("bp resp1 float", respFloat, 32'h41a0_0000);
    respReady[1] = 1'b1;
    @(negedge clk);
    respReady = '0;

    // Reset while the converter is running
    applyStimulus(0, 32'd7, 8'd0);
    @(negedge clk);
    reqValid = '0;
    repeat (10) @(negedge clk);
    checkOutput("mid busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("mid busy",       32'(busy),      32'd0);
    checkOutput("mid cvt_load",   32'(cvtLoad),   32'd0);
    checkOutput("mid resp_valid", 32'(respValid), 32'd0);
    checkOutput("mid req_ready",  32'(reqReady),  32'd0);
    checkOutput("mid resp_float", respFloat,      32'd0);
    reset = 1'b0;
    begin
      int seen = 0;
      for (int c = 0; c < 80; c++) begin
        if (respValid != '0 || busy) seen++;
        @(negedge clk);
      end
      checkOutput("mid abandoned", 32'(seen), 32'd0);
    end
    runOne(1, 32'd7, 8'd0, 32'h40e0_0000, LAT + 2, "after_reset");

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule

// File: doc/fpu_cvt_sched.md
# fpu_cvt_sched

Round-robin scheduler that shares the single iterative fixed-to-float `converter` between `NREQ` requesters in the FPU. Each requester uses a valid/ready request channel and a valid/ready response channel. The scheduler latches operands, pulses the converter's `load_new`, and waits a fixed settle count. It then captures the float and returns it to the granted requester. It sits between the issue logic and the converter instance, which is instantiated alongside it in the FPU top.

## Interface
- `NREQ`, 2 — number of requesters (2..8).
- `CONV_LATENCY`, 64 — cycles from `cvt_load` deassertion until `cvt_float` is valid; ≥1.
- `clk` in 1 — single clock.
- `reset` in 1 — synchronous, active-high.
- `req_valid` in NREQ — request valid, one bit per requester.
- `req_ready` out NREQ — request accepted (grant) strobe.
- `req_fixed` in NREQ×32 — two's-complement integer operand; slice i belongs to requester i.
- `req_exp` in NREQ×8 — signed power-of-two exponent; slice i belongs to requester i.
- `resp_valid` out NREQ — result valid; at most one bit set.
- `resp_ready` in NREQ — result consumed.
- `resp_float` out 32 — IEEE-754 single result; shared by all requesters.
- `cvt_fixed` out 32, `cvt_exp` out 8, `cvt_load` out 1 — drive converter `fixed`, `exp_in`, `load_new`.
- `cvt_float` in 32 — converter `float` output.
- `busy` out 1 — high in any state other than IDLE.

## Operation
- States: IDLE, LOAD, WAIT, RESP. Registers: `grant` index, RR pointer `ptr`, operand regs, `result`, down-counter `cnt` of width clog2(CONV_LATENCY+1).
- IDLE:
  - Grant the first requester with `req_valid` set, scanning from `ptr` upward with wrap.
  - `req_ready[grant]` is combinational and high only in IDLE with a valid winner.
  - On the handshake, latch `req_fixed`/`req_exp` of the winner, record `grant`, and go to LOAD.
- LOAD: `cvt_load`=1 for exactly one cycle. Load `cnt`=CONV_LATENCY-1. Go to WAIT.
- WAIT: decrement `cnt`. In the cycle `cnt`==0, register `result`←`cvt_float` and go to RESP.
- RESP:
  - `resp_valid[grant]`=1 and `resp_float`=`result`, both held stable until `resp_ready[grant]`.
  - On the handshake, `ptr`←(grant+1) mod NREQ and return to IDLE.
  - `resp_ready` bits of other requesters are ignored.
- `cvt_fixed`/`cvt_exp` always show the operand regs, so they are stable for the whole conversion.
- A requester may drop `req_valid` before grant; it is not latched.
- Negative `req_fixed` and negative exponents pass through untouched; the converter owns the sign and exponent arithmetic.

## Timing
- Reset values:
  - State IDLE, `ptr`=0, `grant`=0, `cnt`=0, operands and `result`=0.
  - Outputs: `req_ready`=0 (until a valid request is present), `resp_valid`=0, `cvt_load`=0, `busy`=0, `resp_float`=0.
- Request handshake in cycle T:
  - `cvt_load` high in T+1.
  - WAIT covers T+2 … T+1+CONV_LATENCY.
  - `resp_valid` rises at T+2+CONV_LATENCY.
- With `resp_ready` already high, the next request can be granted at T+3+CONV_LATENCY.
- Simultaneous requests: the lowest index at or after `ptr` wins. After reset, requester 0 beats requester 1.
- Sustained contention alternates grants; no requester waits more than NREQ-1 conversions.
- Reset mid-operation (any state): the request is abandoned with no response. `cvt_load` is low the next cycle. The converter's internal state is don't-care because the next LOAD reloads it.
- No throughput overlap: one conversion in flight.

## Configuration
- `FPU_CVT_SCHED_ZERO_BYPASS_EN` defined:
  - A granted request with `req_fixed`==0 skips LOAD/WAIT and goes straight to RESP with `result`=32'h0000_0000.
  - `resp_valid` rises at T+1.
  - `cvt_load` is not pulsed.
- Undefined: zero operands take the full converter path, with the same latency as any other value.

## Structure
- Package `fpu_cvt_pkg`: state enum (IDLE/LOAD/WAIT/RESP), `FIXED_W`=32, `EXP_W`=8, `FLOAT_W`=32, `FLOAT_ZERO` constant.
- Sub-module `fpu_rr_pick`: combinational round-robin picker with inputs (`req_valid`, `ptr`) and outputs (`gnt_idx`, `gnt_any`). The FSM stays in `fpu_cvt_sched`.

## Test plan
Each bench instantiates `fpu_cvt_sched` with a real `converter`, CONV_LATENCY=64.
- Req0 `fixed`=1, `exp`=0 → `cvt_load` pulse at T+1; `resp_valid[0]` at T+66; `resp_float`=32'h3f80_0000.
- Req1 `fixed`=1, `exp`=1 → 32'h4000_0000. Req0 `fixed`=13, `exp`=8'd255 → 32'h40d0_0000. Req0 `fixed`=32'hffff_ffff, `exp`=0 → 32'hbf80_0000.
- Contention: both requesters valid from reset with distinct operands → grant order 0, 1, 0, 1; each response goes only to its owner with its correct value.
- Backpressure: hold `resp_ready[0]`=0 for 20 cycles → `resp_valid`/`resp_float` stable; req1 not granted until the handshake completes.
- Reset asserted in WAIT → next cycle state IDLE, all outputs at reset values, no `resp_valid`. A subsequent request converts correctly.
- Zero operand `fixed`=0 → with the macro: response 32'h0 at T+1 and no `cvt_load`. Without the macro: response 32'h0 at T+66.
